// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter.
//   arb_port_t : which requester owns an access (fetch or load/store).
//   arb_req_t  : one request as presented to the SRAM mux.
//   rr_pick    : round-robin winner between the two requesters.
package sram_arb_pkg;

  localparam int LEN_ADDR = 32;
  localparam int LEN_DATA = 64;
  localparam int LEN_STRB = LEN_DATA / 8;

  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} arb_port_t;

  typedef struct packed {
    logic [LEN_ADDR-1:0] addr;
    logic [LEN_DATA-1:0] wdata;
    logic [LEN_STRB-1:0] wstrb;
  } arb_req_t;

  // On a conflict the port that did not win last time goes first.
  // With a single eligible port that port wins; with none the result is unused.
  function automatic arb_port_t rr_pick(logic elig_if, logic elig_d, arb_port_t last);
    if (elig_if && elig_d) begin
      return (last == PORT_D) ? PORT_IF : PORT_D;
    end else if (elig_d) begin
      return PORT_D;
    end else begin
      return PORT_IF;
    end
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and SRAM macro signals.
//   slave  : the arbiter's view.
//   master : the view of the core side plus the SRAM macro.
// Handshake rule for every channel: a transfer happens in a cycle where valid
// and ready are both high; valid never waits for ready, while ready may depend
// combinationally on valid (and req_ready on resp_ready).
// The dbg_* signals expose the arbiter's internal state for observation.
interface sram_port_arbiter_if;
  import sram_arb_pkg::*;

  logic                if_req_valid;
  logic                if_req_ready;
  logic [LEN_ADDR-1:0] if_req_addr;
  logic                if_resp_valid;
  logic                if_resp_ready;
  logic [LEN_DATA-1:0] if_resp_data;

  logic                d_req_valid;
  logic                d_req_ready;
  logic [LEN_ADDR-1:0] d_req_addr;
  logic [LEN_DATA-1:0] d_req_wdata;
  logic [LEN_STRB-1:0] d_req_wstrb;
  logic                d_resp_valid;
  logic                d_resp_ready;
  logic [LEN_DATA-1:0] d_resp_data;

  logic [LEN_ADDR-1:0] sram_addra;
  logic [LEN_DATA-1:0] sram_dina;
  logic [LEN_STRB-1:0] sram_wea;
  logic                sram_ena;
  logic [LEN_DATA-1:0] sram_douta;

  arb_port_t           dbg_last_grant;
  logic                dbg_inflight_v;
  arb_port_t           dbg_inflight_port;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb, d_resp_ready,
    input  sram_douta,
    output if_req_ready, if_resp_valid, if_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output sram_addra, sram_dina, sram_wea, sram_ena,
    output dbg_last_grant, dbg_inflight_v, dbg_inflight_port
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output d_req_valid, d_req_addr, d_req_wdata, d_req_wstrb, d_resp_ready,
    output sram_douta,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  sram_addra, sram_dina, sram_wea, sram_ena,
    input  dbg_last_grant, dbg_inflight_v, dbg_inflight_port
  );

endinterface

// File: rtl/sram_arb_resp_slot.sv
// One-entry response skid for one arbiter port.
//   hit        : this port owns the SRAM access issued last cycle.
//   douta      : SRAM read data (valid only while hit is high).
//   resp_ready : consumer accepts the response.
//   resp_valid / resp_data : response toward the consumer.
//   full       : skid holds an unconsumed word; the port must not be granted.
module sram_arb_resp_slot
  import sram_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic [LEN_DATA-1:0] douta,
  input  logic                resp_ready,
  output logic                resp_valid,
  output logic [LEN_DATA-1:0] resp_data,
  output logic                full
);

  logic                full_q, full_d;
  logic [LEN_DATA-1:0] skid_q, skid_d;

  // douta only lives for one cycle, so a refused pass-through word is parked.
  // hit and full_q never coincide: the port is not granted while full.
  always_comb begin
    full_d = full_q;
    skid_d = skid_q;
    if (full_q) begin
      if (resp_ready) full_d = 1'b0;
    end else if (hit && !resp_ready) begin
      full_d = 1'b1;
      skid_d = douta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      skid_q <= '0;
    end else begin
      full_q <= full_d;
      skid_q <= skid_d;
    end
  end

  assign resp_valid = full_q | hit;
  assign resp_data  = full_q ? skid_q : (hit ? douta : '0);
  assign full       = full_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port byte-write SRAM between the fetch path (read-only)
// and the load/store path. Round-robin arbitration on conflict, one access per
// cycle, response one cycle after issue, one-entry skid per port.
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : fetch/load-store request+response channels, SRAM macro pins,
//              and debug view of last_grant / in-flight tag.
module sram_port_arbiter
  import sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   bus
);

  arb_port_t last_grant_q, last_grant_d;
  logic      inflight_v_q, inflight_v_d;
  arb_port_t inflight_port_q, inflight_port_d;

  logic      if_full, d_full;
  logic      if_hit, d_hit;
  logic      elig_if, elig_d;
  logic      gnt_v;
  arb_port_t gnt_port;
  arb_req_t  if_req, d_req, win_req;

  assign if_hit = inflight_v_q && (inflight_port_q == PORT_IF);
  assign d_hit  = inflight_v_q && (inflight_port_q == PORT_D);

  // A port whose response is arriving now but is refused will need its skid,
  // so it cannot take a new access this cycle. Reset blocks every grant so
  // nothing reaches the SRAM while rst is high.
  assign elig_if = !rst && bus.if_req_valid && !if_full && !(if_hit && !bus.if_resp_ready);
  assign elig_d  = !rst && bus.d_req_valid  && !d_full  && !(d_hit  && !bus.d_resp_ready);

  assign gnt_v    = elig_if | elig_d;
  assign gnt_port = rr_pick(elig_if, elig_d, last_grant_q);

  always_comb begin
    if_req       = '0;
    if_req.addr  = bus.if_req_addr;
    d_req        = '0;
    d_req.addr   = bus.d_req_addr;
    d_req.wdata  = bus.d_req_wdata;
    d_req.wstrb  = bus.d_req_wstrb;
    win_req      = '0;
    if (gnt_v) win_req = (gnt_port == PORT_D) ? d_req : if_req;
  end

  assign bus.sram_ena     = gnt_v;
  assign bus.sram_addra   = win_req.addr;
  assign bus.sram_dina    = win_req.wdata;
  assign bus.sram_wea     = win_req.wstrb;
  assign bus.if_req_ready = gnt_v && (gnt_port == PORT_IF);
  assign bus.d_req_ready  = gnt_v && (gnt_port == PORT_D);

  always_comb begin
    inflight_v_d    = gnt_v;
    inflight_port_d = gnt_port;
    last_grant_d    = gnt_v ? gnt_port : last_grant_q;
  end

  // last_grant resets to D so the first conflict goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_v_q    <= 1'b0;
      inflight_port_q <= PORT_IF;
      last_grant_q    <= PORT_D;
    end else begin
      inflight_v_q    <= inflight_v_d;
      inflight_port_q <= inflight_port_d;
      last_grant_q    <= last_grant_d;
    end
  end

  sram_arb_resp_slot u_if_slot (
    .clk        (clk),
    .rst        (rst),
    .hit        (if_hit),
    .douta      (bus.sram_douta),
    .resp_ready (bus.if_resp_ready),
    .resp_valid (bus.if_resp_valid),
    .resp_data  (bus.if_resp_data),
    .full       (if_full)
  );

  sram_arb_resp_slot u_d_slot (
    .clk        (clk),
    .rst        (rst),
    .hit        (d_hit),
    .douta      (bus.sram_douta),
    .resp_ready (bus.d_resp_ready),
    .resp_valid (bus.d_resp_valid),
    .resp_data  (bus.d_resp_data),
    .full       (d_full)
  );

  assign bus.dbg_last_grant    = last_grant_q;
  assign bus.dbg_inflight_v    = inflight_v_q;
  assign bus.dbg_inflight_port = inflight_port_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port front end that shares one single-port, byte-write-enable `sram` instance between the instruction-fetch path (read-only) and the load/store path (read/write). Each requester gets a valid/ready request channel and a valid/ready response channel. Conflicts are arbitrated round-robin, and each SRAM access is tagged with its owner. Each port has a one-entry response skid so the SRAM read data, which is only valid in the cycle after `ena`, is never lost under backpressure. The block sits between the core's fetch/LSU and the `sram` macro.

## Interface
- `LEN_ADDR`, 32, byte address width (same as `sram`).
- `LEN_DATA`, 64, SRAM word width; `LEN_DATA/8` byte strobes.

- `clk`  in  1  clock; also drives `sram.clka`.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_req_addr`  in  LEN_ADDR  fetch byte address.
- `if_resp_valid`  out  1  fetch data valid.
- `if_resp_ready`  in  1  fetch consumer accepts data.
- `if_resp_data`  out  LEN_DATA  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted.
- `d_req_addr`  in  LEN_ADDR  data byte address.
- `d_req_wdata`  in  LEN_DATA  store data.
- `d_req_wstrb`  in  LEN_DATA/8  byte strobes; all-zero means load.
- `d_resp_valid`  out  1  data response valid (loads and stores).
- `d_resp_ready`  in  1  LSU accepts response.
- `d_resp_data`  out  LEN_DATA  loaded word; for a store, the merged post-write word.
- `sram_addra`  out  LEN_ADDR  to `sram.addra`.
- `sram_dina`  out  LEN_DATA  to `sram.dina`.
- `sram_wea`  out  LEN_DATA/8  to `sram.wea`.
- `sram_ena`  out  1  to `sram.ena`.
- `sram_douta`  in  LEN_DATA  from `sram.douta`; valid the cycle after `ena`, zero otherwise.

## Operation
- **Eligibility.** A port is eligible when its `req_valid` is high, its skid is empty, and it is not the case that the port has an in-flight access while its `resp_ready` is low. The combinational path `resp_ready` → `req_ready` is intended.
- **Grant.**
  - At most one grant per cycle.
  - If exactly one port is eligible, that port wins.
  - If both are eligible, the port that did not win the most recent grant wins (round-robin via `last_grant`).
- **Issue.** `req_ready` is high only for the granted port.
  - `sram_ena` = any grant.
  - `sram_addra` and `sram_dina` come from the winner.
  - `sram_wea` = `d_req_wstrb` if D wins; all-zero if IF wins.
  - With no grant: `sram_ena`=0, `sram_wea`=0, address and data are don't-care.
- **In-flight tracking.** Registers `inflight_v` and `inflight_port` record the access issued last cycle.
- **Response.** In the cycle after issue, the owning port sees `resp_valid`=1 and `resp_data`=`sram_douta`.
  - If `resp_ready`=0 that cycle, `sram_douta` is captured into the port's skid.
  - `resp_valid` stays 1 with the skid data until `resp_ready`=1.
  - While the skid is full, data comes from the skid, never from `sram_douta`.
- **Ordering.** Responses are in request order per port. No ordering is guaranteed across ports, except that a D store issued before an IF read of the same word is visible to that read.
- **Reset (async, any time).**
  - Outputs: all `req_ready`=0, `resp_valid`=0, `resp_data`=0, `sram_ena`=0, `sram_wea`=0.
  - State: `inflight_v`=0, skids empty.
  - `last_grant`=D, so IF wins the first conflict.
  - An access in flight at reset is dropped with no response. The SRAM array contents are not reset.

## Timing
- Request-to-response latency is 1 cycle (response in cycle N+1 after handshake in cycle N).
- Throughput:
  - A single active port with `resp_ready` held high gets 1 access per cycle.
  - Under continuous conflict each port gets 1 access per 2 cycles.
- A skid stall costs one extra cycle per held response, and the port is not re-granted until the skid drains.
- Store-to-load: a D store in cycle N followed by an IF read of the same address in cycle N+1 returns the new data in N+2.
- Registered outputs: skid data/valid, `inflight_*`, `last_grant`. Combinational outputs: `req_ready`, `sram_*`, and `resp_*` in the pass-through case.

## Structure
- Package `sram_arb_pkg`:
  - `typedef enum logic {PORT_IF=1'b0, PORT_D=1'b1} arb_port_t`.
  - Struct `arb_req_t` {addr, wdata, wstrb}.
- Sub-module `sram_arb_resp_slot` (instantiated twice):
  - Inputs: `hit`, `douta`, `resp_ready`.
  - Outputs: `resp_valid`, `resp_data`, `full`.
  - Contents: a one-entry skid register with its own async reset.
- Top level: eligibility, round-robin grant, SRAM mux, in-flight tag. The `sram` instance lives outside this block.

## Test plan
- IF-only burst: reads of 0x0, 0x8, 0x10 on consecutive cycles with `resp_ready`=1 → `if_resp_valid` in 3 consecutive cycles, data = preloaded words, `sram_ena` high 3 cycles.
- Simultaneous: both ports valid for 4 cycles after reset → grants IF, D, IF, D; `last_grant` alternates.
- Store then fetch: D writes 0xDEADBEEF_00000000 with wstrb 0xF0 to 0x20 (old word 0x11111111_22222222) → `d_resp_data` = 0xDEADBEEF_22222222; IF read of 0x20 next cycle returns the same value.
- Backpressure: `if_resp_ready`=0 for 3 cycles during a response → data held stable in the skid, `if_req_ready`=0 and no IF issue until drained, D traffic continues.
- Mid-flight reset: assert `rst` the cycle after a D load issue → no `d_resp_valid`; all outputs 0 during reset; the first conflict after release is granted to IF.
